// File: rtl/issue_queue_nw_pkg.sv
// Shared types and helpers for the issue queue.
// Provides instr_t, NOP_INSTR and the leading-ones counter.
package issue_pkg;

    localparam int XLEN  = 32;
    localparam int MAX_W = 4;

    typedef logic [XLEN-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'd0;

    // Length of the run of ones starting at bit 0.
    function automatic int unsigned popcount_lead(
        input logic [MAX_W-1:0] v
    );
        int unsigned n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            run = run & v[i];
            if (run) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/issue_queue_nw_if.sv
// Fetch and issue bundle of the issue queue.
// master: fetch/scheduler side, slave: the queue itself.
interface issue_queue_nw_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int BW      = $clog2(ISSUE_W + 1)
);
    logic                    fetch_valid;
    logic                    fetch_ready;
    logic [BW-1:0]           fetch_count;
    logic [ISSUE_W*XLEN-1:0] fetch_instr;
    logic [ISSUE_W-1:0]      freeze;
    logic [ISSUE_W*XLEN-1:0] issue_instr;
    logic [ISSUE_W-1:0]      issue_valid;
    logic [ISSUE_W-1:0]      issue_fire;
    logic [CNT_W-1:0]        occupancy;
    logic                    nothing_filled;
    logic                    full;

    modport master (
        output fetch_valid, fetch_count, fetch_instr, freeze,
        input  fetch_ready, issue_instr, issue_valid, issue_fire,
        input  occupancy, nothing_filled, full
    );

    modport slave (
        input  fetch_valid, fetch_count, fetch_instr, freeze,
        output fetch_ready, issue_instr, issue_valid, issue_fire,
        output occupancy, nothing_filled, full
    );
endinterface

// File: rtl/issue_queue_nw_storage.sv
// DEPTH x XLEN register array for the issue queue.
// Ports: i_we/i_waddr/i_wdata write ISSUE_W consecutive wrapped slots,
// i_raddr/o_rdata read ISSUE_W consecutive wrapped slots.
module iq_storage #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2
) (
    input  logic                       clk,
    input  logic [ISSUE_W-1:0]         i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [ISSUE_W*XLEN-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [ISSUE_W*XLEN-1:0]    o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]   w_wa  [ISSUE_W];
    logic [AW-1:0]   w_ra  [ISSUE_W];

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            w_wa[i] = i_waddr + AW'(i);
            w_ra[i] = i_raddr + AW'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_W; i++) begin
            if (i_we[i]) r_mem[w_wa[i]] <= i_wdata[i*XLEN +: XLEN];
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
        assign o_rdata[g*XLEN +: XLEN] = r_mem[w_ra[g]];
    end
endmodule

// File: rtl/issue_queue_nw.sv
// In-order issue queue: ISSUE_W-wide fetch in, ISSUE_W lanes out.
// Ports: clk, n_rst (async low), i_en strobe, i_flush, io_q bundle.
module issue_queue_nw
    import issue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i_en,
    input  logic                i_flush,
    issue_queue_nw_if.slave     io_q
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(ISSUE_W + 1);

    logic [PW-1:0]           r_rd_ptr;
    logic [PW-1:0]           r_wr_ptr;
    logic [CNT_W-1:0]        r_occ;
    logic [ISSUE_W-1:0]      w_valid;
    logic [ISSUE_W-1:0]      w_fire;
    logic [ISSUE_W-1:0]      w_we;
    logic [CNT_W-1:0]        w_pops;
    logic [CNT_W-1:0]        w_pushes;
    logic                    w_run;
    logic                    w_ready;
    logic                    w_accept;
    logic [ISSUE_W*XLEN-1:0] w_rdata;

    // A lane fires only if every older lane fires too.
    always_comb begin
        w_run   = i_en & ~i_flush;
        w_valid = '0;
        w_fire  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_valid[i] = r_occ > CNT_W'(i);
            w_run      = w_run & w_valid[i] & ~io_q.freeze[i];
            w_fire[i]  = w_run;
        end
    end

    assign w_pops = CNT_W'(popcount_lead(MAX_W'(w_fire)));

    // Space check uses registered occupancy only.
    assign w_ready = ({1'b0, r_occ} + (CNT_W+1)'(ISSUE_W))
                     <= (CNT_W+1)'(DEPTH);

    assign w_accept = i_en & ~i_flush & io_q.fetch_valid & w_ready;

    always_comb begin
        w_pushes = '0;
        if (w_accept) begin
            if (io_q.fetch_count > BW'(ISSUE_W))
                w_pushes = CNT_W'(ISSUE_W);
            else
                w_pushes = CNT_W'(io_q.fetch_count);
        end
        for (int i = 0; i < ISSUE_W; i++)
            w_we[i] = CNT_W'(i) < w_pushes;
    end

    iq_storage #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (io_q.fetch_instr),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else if (i_en) begin
            r_occ    <= r_occ - w_pops + w_pushes;
            r_rd_ptr <= r_rd_ptr + PW'(w_pops);
            r_wr_ptr <= r_wr_ptr + PW'(w_pushes);
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        assign io_q.issue_instr[g*XLEN +: XLEN] =
            w_valid[g] ? w_rdata[g*XLEN +: XLEN] : XLEN'(NOP_INSTR);
    end

    assign io_q.issue_valid    = w_valid;
    assign io_q.issue_fire     = w_fire;
    assign io_q.occupancy      = r_occ;
    assign io_q.nothing_filled = (r_occ == '0);
    assign io_q.full           = (r_occ == CNT_W'(DEPTH));
    assign io_q.fetch_ready    = w_ready;

    a_cnt: assert property (@(posedge clk) disable iff (!n_rst)
        io_q.fetch_count <= BW'(ISSUE_W));
    a_occ: assert property (@(posedge clk) disable iff (!n_rst)
        r_occ <= CNT_W'(DEPTH));
    a_push: assert property (@(posedge clk) disable iff (!n_rst)
        !w_ready |-> (w_pushes == '0));
    a_lead: assert property (@(posedge clk) disable iff (!n_rst)
        (w_fire & ISSUE_W'(w_fire + 1'b1)) == '0);
    a_ptr: assert property (@(posedge clk) disable iff (!n_rst)
        PW'(r_wr_ptr - r_rd_ptr) == PW'(r_occ));
endmodule

// File: tb/tb_issue_queue_nw.sv
// Directed self-checking bench for issue_queue_nw.
// DEPTH=8, ISSUE_W=2, XLEN=32.
module tb_issue_queue_nw;
    logic clk;
    logic n_rst;
    logic en;
    logic flush;
    int   total;
    int   bad;

    issue_queue_nw_if bus ();

    issue_queue_nw u_dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_en    (en),
        .i_flush (flush),
        .io_q    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic drive(input logic e, input logic f, input logic fv,
                         input logic [1:0] fc, input logic [31:0] s0,
                         input logic [31:0] s1, input logic [1:0] fz);
        en               = e;
        flush            = f;
        bus.fetch_valid  = fv;
        bus.fetch_count  = fc;
        bus.fetch_instr  = {s1, s0};
        bus.freeze       = fz;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", bus.occupancy); end
        total++; if (bus.issue_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", bus.issue_valid); end
        total++; if (bus.issue_instr !== 64'd0) begin bad++; $display("FAIL rst_instr got=%h want=0", bus.issue_instr); end
        total++; if (bus.nothing_filled !== 1'b1) begin bad++; $display("FAIL rst_nf got=%b want=1", bus.nothing_filled); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", bus.full); end
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.fetch_ready); end
        total++; if (bus.issue_fire !== 2'b00) begin bad++; $display("FAIL rst_fire got=%b want=00", bus.issue_fire); end
        tick();
        n_rst = 1'b1;
        drive(1, 0, 1, 2, 32'h11, 32'h22, 2'b01);
        tick();
        drive(1, 0, 1, 1, 32'h33, 32'h0, 2'b01);
        tick();
        total++; if (bus.occupancy !== 4'd3) begin bad++; $display("FAIL midfill_occ got=%0d want=3", bus.occupancy); end
        n_rst = 1'b0;
        #1;
        total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL midrst_occ got=%0d want=0", bus.occupancy); end
        total++; if (bus.issue_valid !== 2'b00) begin bad++; $display("FAIL midrst_valid got=%b want=00", bus.issue_valid); end
        total++; if (bus.issue_instr !== 64'd0) begin bad++; $display("FAIL midrst_instr got=%h want=0", bus.issue_instr); end
        drive(1, 0, 0, 0, 0, 0, 2'b01);
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_fill();
        drive(1, 0, 1, 2, 32'hA, 32'hB, 2'b01);
        tick();
        drive(1, 0, 1, 2, 32'hC, 32'hD, 2'b01);
        tick();
        drive(1, 0, 0, 0, 0, 0, 2'b01);
        total++; if (bus.occupancy !== 4'd4) begin bad++; $display("FAIL fill_occ got=%0d want=4", bus.occupancy); end
        total++; if (bus.issue_valid !== 2'b11) begin bad++; $display("FAIL fill_valid got=%b want=11", bus.issue_valid); end
        total++; if (bus.issue_instr[31:0] !== 32'hA) begin bad++; $display("FAIL fill_lane0 got=%h want=a", bus.issue_instr[31:0]); end
        total++; if (bus.issue_instr[63:32] !== 32'hB) begin bad++; $display("FAIL fill_lane1 got=%h want=b", bus.issue_instr[63:32]); end
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL fill_ready got=%b want=1", bus.fetch_ready); end
    endtask

    task automatic test_freeze();
        total++; if (bus.issue_fire !== 2'b00) begin bad++; $display("FAIL frz01_fire got=%b want=00", bus.issue_fire); end
        tick();
        total++; if (bus.occupancy !== 4'd4) begin bad++; $display("FAIL frz01_occ got=%0d want=4", bus.occupancy); end
        total++; if (bus.issue_instr[31:0] !== 32'hA) begin bad++; $display("FAIL frz01_lane0 got=%h want=a", bus.issue_instr[31:0]); end
        drive(1, 0, 0, 0, 0, 0, 2'b10);
        total++; if (bus.issue_fire !== 2'b01) begin bad++; $display("FAIL frz10_fire got=%b want=01", bus.issue_fire); end
        tick();
        total++; if (bus.issue_instr[31:0] !== 32'hB) begin bad++; $display("FAIL frz10_lane0 got=%h want=b", bus.issue_instr[31:0]); end
        total++; if (bus.issue_instr[63:32] !== 32'hC) begin bad++; $display("FAIL frz10_lane1 got=%h want=c", bus.issue_instr[63:32]); end
        total++; if (bus.occupancy !== 4'd3) begin bad++; $display("FAIL frz10_occ got=%0d want=3", bus.occupancy); end
    endtask

    task automatic test_empty();
        drive(0, 1, 0, 0, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        total++; if (bus.nothing_filled !== 1'b1) begin bad++; $display("FAIL empty_nf got=%b want=1", bus.nothing_filled); end
        total++; if (bus.issue_fire !== 2'b00) begin bad++; $display("FAIL empty_fire got=%b want=00", bus.issue_fire); end
        total++; if (bus.issue_valid !== 2'b00) begin bad++; $display("FAIL empty_valid got=%b want=00", bus.issue_valid); end
        total++; if (bus.issue_instr !== 64'd0) begin bad++; $display("FAIL empty_instr got=%h want=0", bus.issue_instr); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] head;
        logic [31:0] nxt;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 2, 32'h100 + 2*k, 32'h101 + 2*k, 2'b01);
            tick();
        end
        drive(1, 0, 1, 2, 32'hDEAD, 32'hBEEF, 2'b01);
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", bus.full); end
        total++; if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", bus.fetch_ready); end
        total++; if (bus.occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d want=8", bus.occupancy); end
        tick();
        total++; if (bus.occupancy !== 4'd8) begin bad++; $display("FAIL full_drop_occ got=%0d want=8", bus.occupancy); end
        total++; if (bus.issue_instr[31:0] !== 32'h100) begin bad++; $display("FAIL full_lane0 got=%h want=100", bus.issue_instr[31:0]); end
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        total++; if (bus.issue_fire !== 2'b11) begin bad++; $display("FAIL full_pop_fire got=%b want=11", bus.issue_fire); end
        tick();
        total++; if (bus.occupancy !== 4'd6) begin bad++; $display("FAIL full_pop_occ got=%0d want=6", bus.occupancy); end
        head = 32'h102;
        nxt  = 32'h108;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 1, 2, nxt, nxt + 1, 2'b00);
            total++; if (bus.issue_instr[31:0] !== head) begin bad++; $display("FAIL wrap_lane0 k=%0d got=%h want=%h", k, bus.issue_instr[31:0], head); end
            total++; if (bus.issue_instr[63:32] !== head + 1) begin bad++; $display("FAIL wrap_lane1 k=%0d got=%h want=%h", k, bus.issue_instr[63:32], head + 1); end
            total++; if (bus.issue_fire !== 2'b11) begin bad++; $display("FAIL wrap_fire k=%0d got=%b want=11", k, bus.issue_fire); end
            tick();
            head = head + 2;
            nxt  = nxt + 2;
            total++; if (bus.occupancy !== 4'd6) begin bad++; $display("FAIL wrap_occ k=%0d got=%0d want=6", k, bus.occupancy); end
        end
    endtask

    task automatic test_count1();
        drive(0, 1, 0, 0, 0, 0, 2'b01);
        tick();
        drive(1, 0, 1, 1, 32'hAA, 32'hBB, 2'b01);
        tick();
        total++; if (bus.issue_valid !== 2'b01) begin bad++; $display("FAIL c1_valid got=%b want=01", bus.issue_valid); end
        total++; if (bus.issue_instr[63:32] !== 32'h0) begin bad++; $display("FAIL c1_nop got=%h want=0", bus.issue_instr[63:32]); end
        drive(1, 0, 1, 1, 32'hCC, 32'hDD, 2'b01);
        tick();
        total++; if (bus.occupancy !== 4'd2) begin bad++; $display("FAIL c1_occ got=%0d want=2", bus.occupancy); end
        total++; if (bus.issue_instr[31:0] !== 32'hAA) begin bad++; $display("FAIL c1_lane0 got=%h want=aa", bus.issue_instr[31:0]); end
        total++; if (bus.issue_instr[63:32] !== 32'hCC) begin bad++; $display("FAIL c1_lane1 got=%h want=cc", bus.issue_instr[63:32]); end
    endtask

    task automatic test_flush_en0();
        drive(0, 1, 0, 0, 0, 0, 2'b01);
        tick();
        drive(1, 0, 1, 2, 32'h1, 32'h2, 2'b01);
        tick();
        drive(1, 0, 1, 2, 32'h3, 32'h4, 2'b01);
        tick();
        drive(1, 0, 1, 1, 32'h5, 32'h6, 2'b01);
        tick();
        drive(0, 0, 1, 2, 32'h66, 32'h67, 2'b00);
        total++; if (bus.issue_fire !== 2'b00) begin bad++; $display("FAIL en0_fire got=%b want=00", bus.issue_fire); end
        tick();
        total++; if (bus.occupancy !== 4'd5) begin bad++; $display("FAIL en0_occ got=%0d want=5", bus.occupancy); end
        total++; if (bus.issue_instr[31:0] !== 32'h1) begin bad++; $display("FAIL en0_lane0 got=%h want=1", bus.issue_instr[31:0]); end
        drive(0, 1, 1, 2, 32'h77, 32'h88, 2'b00);
        total++; if (bus.issue_fire !== 2'b00) begin bad++; $display("FAIL fl_fire got=%b want=00", bus.issue_fire); end
        tick();
        total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL fl_occ got=%0d want=0", bus.occupancy); end
        total++; if (bus.nothing_filled !== 1'b1) begin bad++; $display("FAIL fl_nf got=%b want=1", bus.nothing_filled); end
        total++; if (bus.issue_valid !== 2'b00) begin bad++; $display("FAIL fl_valid got=%b want=00", bus.issue_valid); end
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        tick();
        total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL fl_drop_occ got=%0d want=0", bus.occupancy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_freeze();
        test_empty();
        test_full_wrap();
        test_count1();
        test_flush_en0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
